// File: rtl/binary_to_bcd_if.sv
// Sample/result bundle for the binary-to-BCD converter: the input qualifier and data go in,
// and the valid strobe, packed BCD and per-digit breakouts come back.
interface binary_to_bcd_if #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic [DATA_W-1:0]     data;
    logic                  out_valid;
    logic [3:0]            bit0;
    logic [3:0]            bit1;
    logic [3:0]            bit2;
    logic [4*DIGITS-1:0]   BCD;

    modport master (
        output in_valid, data,
        input  out_valid, bit0, bit1, bit2, BCD
    );

    modport slave (
        input  in_valid, data,
        output out_valid, bit0, bit1, bit2, BCD
    );
endinterface

// File: rtl/binary_to_bcd.sv
// Double-dabble binary-to-BCD converter with registered outputs and a valid strobe.
// Define BIN2BCD_PIPELINE_EN to register every add-3/shift iteration (latency DATA_W+1 instead of 1).
module binary_to_bcd #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    binary_to_bcd_if.slave  bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam longint unsigned MAX_IN = (64'd1 << DATA_W) - 64'd1;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    if ((DATA_W < 4) || (DATA_W > 16)) begin : g_bad_data_w
        $error("binary_to_bcd: DATA_W=%0d outside 4..16", DATA_W);
    end
    if (pow10(DIGITS) <= MAX_IN) begin : g_bad_digits
        $error("binary_to_bcd: DIGITS=%0d too small for DATA_W=%0d", DIGITS, DATA_W);
    end

    // One double-dabble iteration: correct every digit >= 5, then shift in the next data bit.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] acc, input logic din);
        logic [BCD_W-1:0] adj;
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        return {adj[BCD_W-2:0], din};
    endfunction

    logic               fin_vld;
    logic [BCD_W-1:0]   fin_bcd;

`ifdef BIN2BCD_PIPELINE_EN

    // Stage k holds the accumulator after k iterations plus the DATA_W-k data bits still to
    // be shifted in. Those remainders shrink by one bit per stage, so they are packed
    // back-to-back in a single triangular vector rather than a square array.
    localparam int REM_W = (DATA_W * (DATA_W - 1)) / 2;

    function automatic int rem_off(input int k);
        return (k - 1) * DATA_W - ((k - 1) * k) / 2;
    endfunction

    logic [BCD_W-1:0]   acc_q [1:DATA_W];
    logic [BCD_W-1:0]   acc_d [1:DATA_W];
    logic [DATA_W:1]    vld_q;
    logic [DATA_W:1]    vld_d;
    logic [REM_W-1:0]   rem_q;
    logic [REM_W-1:0]   rem_d;

    always_comb begin
        rem_d    = '0;
        acc_d[1] = dabble_step('0, bus.data[DATA_W-1]);
        vld_d[1] = bus.in_valid;
        for (int b = 0; b < DATA_W - 1; b++) begin
            rem_d[b] = bus.data[b];
        end
        for (int k = 2; k <= DATA_W; k++) begin
            acc_d[k] = dabble_step(acc_q[k-1], rem_q[rem_off(k-1) + DATA_W - k]);
            vld_d[k] = vld_q[k-1];
            for (int b = 0; b < DATA_W - k; b++) begin
                rem_d[rem_off(k) + b] = rem_q[rem_off(k-1) + b];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DATA_W; k++) begin
                acc_q[k] <= '0;
            end
            vld_q <= '0;
            rem_q <= '0;
        end else begin
            for (int k = 1; k <= DATA_W; k++) begin
                acc_q[k] <= acc_d[k];
            end
            vld_q <= vld_d;
            rem_q <= rem_d;
        end
    end

    assign fin_vld = vld_q[DATA_W];
    assign fin_bcd = acc_q[DATA_W];

`else

    logic [BCD_W-1:0] bcd_d;

    always_comb begin
        bcd_d = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            bcd_d = dabble_step(bcd_d, bus.data[i]);
        end
    end

    assign fin_vld = bus.in_valid;
    assign fin_bcd = bcd_d;

`endif

    logic               out_valid_q;
    logic [BCD_W-1:0]   bcd_q;

    // The result register only loads on valid samples, so idle cycles hold the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            bcd_q       <= '0;
        end else begin
            out_valid_q <= fin_vld;
            if (fin_vld) begin
                bcd_q <= fin_bcd;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.BCD       = bcd_q;
    assign bus.bit0      = bcd_q[3:0];
    assign bus.bit1      = bcd_q[7:4];

    if (DIGITS >= 3) begin : g_bit2
        assign bus.bit2 = bcd_q[11:8];
    end else begin : g_no_bit2
        assign bus.bit2 = 4'd0;
    end

endmodule

// File: tb/tb_binary_to_bcd.sv
// Scoreboard bench for binary_to_bcd: the driver queues expected results, a negedge monitor checks them.
module tb_binary_to_bcd;

    localparam int DATA_W = 8;
    localparam int DIGITS = 3;
`ifdef BIN2BCD_PIPELINE_EN
    localparam int LAT = DATA_W + 1;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [11:0] bcd;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    binary_to_bcd_if #(.DATA_W(DATA_W), .DIGITS(DIGITS)) bus ();

    binary_to_bcd #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [11:0] hold_exp = 12'h000;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int d);
        return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    // Inputs change 1 time unit after the sampling edge.
    task automatic drive(input bit v, input int d, input logic [11:0] e);
        bus.in_valid = v;
        bus.data     = DATA_W'(d);
        @(posedge clk);
        if (v) sb.push_back('{e, cyc});
        #1;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            drive(1'b0, 7, 12'h000);
            guard++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("bcd", bus.BCD, mon_e.bcd);
                    check("bit0", bus.bit0, mon_e.bcd[3:0]);
                    check("bit1", bus.bit1, mon_e.bcd[7:4]);
                    check("bit2", bus.bit2, mon_e.bcd[11:8]);
                    check("latency", cyc - mon_e.t, LAT);
                    hold_exp = mon_e.bcd;
                end
            end else begin
                check("hold_bcd", bus.BCD, hold_exp);
            end
        end
    end

    int          dv[10] = '{0, 5, 9, 10, 15, 25, 47, 99, 123, 255};
    logic [11:0] de[10] = '{12'h000, 12'h005, 12'h009, 12'h010, 12'h015,
                            12'h025, 12'h047, 12'h099, 12'h123, 12'h255};

    initial begin
        bus.in_valid = 1'b1;
        bus.data     = 8'd255;
        rst_n        = 1'b1;
        #1 rst_n     = 1'b0;
        #1;
        check("reset_async_bcd", bus.BCD, 12'h000);
        check("reset_async_out_valid", bus.out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held_bcd", bus.BCD, 12'h000);
        check("reset_held_out_valid", bus.out_valid, 0);
        check("reset_held_bit0", bus.bit0, 0);
        check("reset_held_bit2", bus.bit2, 0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        drive(1'b0, 0, 12'h000);

        foreach (dv[i]) drive(1'b1, dv[i], de[i]);

        drive(1'b1, 123, 12'h123);
        repeat (3) drive(1'b0, 7, 12'h000);
        wait_drain();
        @(negedge clk);
        check("gap_bcd", bus.BCD, 12'h123);
        check("gap_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;

        drive(1'b1, 47, 12'h047);
        drive(1'b1, 99, 12'h099);
        #1 rst_n = 1'b0;
        #1;
        sb.delete();
        hold_exp = 12'h000;
        check("midreset_bcd", bus.BCD, 12'h000);
        check("midreset_out_valid", bus.out_valid, 0);
        check("midreset_bit1", bus.bit1, 0);
        bus.in_valid = 1'b1;
        bus.data     = 8'd200;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        repeat (LAT + 2) drive(1'b0, 200, 12'h000);
        drive(1'b1, 58, 12'h058);

        for (int d = 0; d < 256; d++) drive(1'b1, d, ref_bcd(d));
        wait_drain();
        repeat (2) drive(1'b0, 0, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/binary_to_bcd.md
Name:
binary_to_bcd

Overview:
- Converts an unsigned binary value on `data` into packed BCD using the shift-and-add-3 (double-dabble) algorithm.
- Outputs are registered, and each decimal digit is also broken out on its own port.
- Sits in the datapath between binary counters or ALU results and decimal display / readout logic.
- Accepts a new sample every clock cycle; a valid strobe travels alongside each result.

Parameters:
- DATA_W, 8, width of the binary input in bits (legal range 4..16).
- DIGITS, 3, number of BCD digits produced; must satisfy 10^DIGITS > 2^DATA_W - 1 (3 for DATA_W=8).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears all state immediately, release is synchronous to clk.
- in_valid  input  1  qualifies `data`; sampled on every rising clk edge.
- data  input  DATA_W  unsigned binary value to convert.
- out_valid  output  1  high for one cycle for each converted sample.
- bit0  output  4  ones digit (BCD[3:0]).
- bit1  output  4  tens digit (BCD[7:4]).
- bit2  output  4  hundreds digit (BCD[11:8]).
- BCD  output  4*DIGITS  packed BCD result, least significant digit in the lowest nibble.

Behaviour:
- Interface: one clock `clk`; asynchronous, active-low reset `rst_n`.
- Reset values: BCD=0, bit0=bit1=bit2=0, out_valid=0, and all pipeline registers cleared.
- Reset asserted mid-operation: in-flight samples are discarded; the first output after release comes only from a sample accepted after release.
- Algorithm:
  - Start with a BCD accumulator of 4*DIGITS bits, all zero.
  - Repeat DATA_W times, MSB first: add 3 to every digit that is >= 5, then shift the accumulator left by one, bringing in the next data bit.
  - The result is exact for every input from 0 to 2^DATA_W-1.
  - No digit ever exceeds 9.
- Default build (feature macro undefined):
  - Conversion is fully combinational from `data` into a single output register.
  - Latency is 1 cycle: data sampled at edge N appears on BCD/bitN after edge N, with out_valid=1 in that same cycle.
- in_valid=0 at an edge:
  - BCD and bit0/bit1/bit2 hold their previous values.
  - out_valid goes to 0.
- Throughput: one conversion per cycle; there is no backpressure.
- Output relationships:
  - bit0/bit1/bit2 are always equal to the corresponding BCD nibbles.
  - For DIGITS > 3, the upper nibbles appear only on BCD.
- Leading zeros: leading digits are output as 0 (no blanking).
- Width rule: a parameter combination with 10^DIGITS <= 2^DATA_W-1 is illegal and must trigger an elaboration-time error.

Optional Feature:
- Macro: BIN2BCD_PIPELINE_EN.
- When defined:
  - Each of the DATA_W add-3/shift iterations gets its own register stage, carrying its partial accumulator, the remaining data bits and the valid bit.
  - Latency is DATA_W+1 cycles (9 for the default); throughput stays one sample per cycle.
  - out_valid marks exactly the cycles whose results come from samples accepted with in_valid=1, in order.
  - While in_valid=0, the outputs hold the most recent valid result.
- When undefined: single-stage behaviour with 1-cycle latency, as described above.
- Results are identical in both builds; only latency differs.

Test Plan:
- Reset: hold rst_n=0 with data=255 and in_valid=1 → BCD=0x000, out_valid=0; assert rst_n mid-stream → outputs clear at once with no clock edge.
- Single digits: data=0, 5, 9 on consecutive cycles → BCD=0x000, 0x005, 0x009 and bit0=0/5/9, each exactly one latency after input.
- Tens crossing: data=10, 15, 25 → bit1=1/1/2 and bit0=0/5/5 (BCD=0x010, 0x015, 0x025).
- Hundreds: data=47, 99, 123, 255 → BCD=0x047, 0x099, 0x123, 0x255; for 255, bit2=2, bit1=5, bit0=5.
- Hold: feed valid 123, then in_valid=0 for 3 cycles with data=7 → BCD stays 0x123 and out_valid=0 during the gap.
- Exhaustive/pipeline: sweep 0..255 back-to-back, then repeat with BIN2BCD_PIPELINE_EN defined → every output matches the decimal reference, with latency exactly 1 or 9 cycles respectively.
